serial_adder_ctrl: RTL and testbench

Bit-serial adder controller that sequences a single 1-bit full-adder cell over a WIDTH-bit operand pair, one bit per clock, LSB first. It latches operands on a start request, runs the carry chain through a carry flip-flop, and presents the assembled sum, carry-out and a one-cycle done pulse. It sits between a register-file or switch-input front end and the display/result logic of the arithmetic lab designs.

---
 rtl/serial_adder_pkg.sv | 24 ++
 rtl/full_adder_cell.sv | 13 +
 rtl/serial_adder_ctrl.sv | 143 ++++++++++++++
 tb/tb_serial_adder_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_adder_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits needed to count 0..value-1; never less than one.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/full_adder_cell.sv
// Single-bit combinational full adder used as the serial arithmetic element.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell stepped LSB first over WIDTH bits.
// Optional SERIAL_ADDER_SUB_EN adds a `sub` input selecting a - b.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CW = clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic [WIDTH-1:0] b_in;
    logic             ci_in;
    logic             fa_s, fa_co;

    // Subtraction is a + ~b + 1, so only the captured B and carry seed change.
`ifdef SERIAL_ADDER_SUB_EN
    assign b_in  = sub ? ~b : b;
    assign ci_in = sub | cin;
`else
    assign b_in  = b;
    assign ci_in = cin;
`endif

    full_adder_cell u_fa (
        .a  (a_sh_q[0]),
        .b  (b_sh_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (cnt_q == LAST_BIT) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next-state and registered output values.
    always_comb begin
        cnt_d   = cnt_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b_in;
                    carry_d = ci_in;
                    cnt_d   = '0;
                    res_d   = '0;
                end
            end
            RUN: begin
                res_d   = {fa_s, res_q[WIDTH-1:1]};
                carry_d = fa_co;
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    cnt_d  = '0;
                    sum_d  = {fa_s, res_q[WIDTH-1:1]};
                    cout_d = fa_co;
                end
            end
            DONE:    ;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8): vector table plus
// multi-cycle sequences, with a result scoreboard.
module tb_serial_adder_ctrl;
    import serial_adder_pkg::*;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a, b;
    logic         cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic         sub;
`endif
    logic         busy, done, cout;
    logic [W-1:0] sum;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
    } vec_t;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(input logic [W-1:0] va, input logic [W-1:0] vb,
                                input logic vc, input logic vs,
                                input logic [W-1:0] es, input logic ec);
        vec_t v;
        v.a = va; v.b = vb; v.cin = vc; v.sub = vs;
        v.exp_sum = es; v.exp_cout = ec;
        return v;
    endfunction

    task automatic push_exp(input logic [W-1:0] es, input logic ec);
        exp_t e;
        e.sum = es;
        e.cout = ec;
        sb.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check({tag, "_sum"}, 32'(sum), 32'(e.sum));
            check({tag, "_cout"}, 32'(cout), 32'(e.cout));
        end
    endtask

    // One full operation from IDLE, checking latency, busy width and result.
    task automatic run_op(input vec_t v, input string tag);
        int  n;
        int  busy_cycles;
        bit  seen;
        @(negedge clk);
        a = v.a; b = v.b; cin = v.cin;
`ifdef SERIAL_ADDER_SUB_EN
        sub = v.sub;
`endif
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_accept_busy"}, 32'(busy), 32'd1);
        push_exp(v.exp_sum, v.exp_cout);
        n = 0; busy_cycles = 1; seen = 1'b0;
        while (!seen && n < 30) begin
            @(negedge clk);
            n++;
            if (busy) busy_cycles++;
            if (done) seen = 1'b1;
        end
        check({tag, "_done_latency"}, 32'(n), 32'd8);
        check({tag, "_busy_cycles"}, 32'(busy_cycles), 32'd9);
        pop_check(tag);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        check({tag, "_busy_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int k;
        int acc, prev_acc;

        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'b0;
`endif

        vecs.push_back(mk(8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0));
        vecs.push_back(mk(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1));
        vecs.push_back(mk(8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1));
        vecs.push_back(mk(8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0));
        vecs.push_back(mk(8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0));
        vecs.push_back(mk(8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1));
        vecs.push_back(mk(8'hA5, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1));
        vecs.push_back(mk(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0));
`ifdef SERIAL_ADDER_SUB_EN
        vecs.push_back(mk(8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1));
        vecs.push_back(mk(8'h01, 8'h02, 1'b0, 1'b1, 8'hFF, 1'b0));
        vecs.push_back(mk(8'h01, 8'h02, 1'b1, 1'b1, 8'hFF, 1'b0));
`endif

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
        end

        // Result holds while idle with start low
        run_op(vecs[0], "hold_setup");
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("hold_sum", 32'(sum), 32'h96);
            check("hold_cout", 32'(cout), 32'd0);
            check("hold_done", 32'(done), 32'd0);
        end

        // start held high: one op every W+2 cycles, operands changed mid-RUN
        @(negedge clk);
        a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
        prev_acc = 0;
        for (int op = 0; op < 3; op++) begin
            k = 0;
            while (busy && k < 20) begin @(negedge clk); k++; end
            k = 0;
            while (!busy && k < 20) begin @(negedge clk); k++; end
            check("cont_accept", 32'(busy), 32'd1);
            acc = cyc;
            if (op > 0) check("cont_spacing", 32'(acc - prev_acc), 32'd10);
            prev_acc = acc;
            push_exp(8'h03, 1'b0);
            a = W'($urandom);
            b = W'($urandom);
            k = 0;
            while (!done && k < 20) begin @(negedge clk); k++; end
            check("cont_done", 32'(done), 32'd1);
            pop_check("cont");
            a = 8'h01; b = 8'h02;
        end
        start = 1'b0;
        repeat (12) @(negedge clk);

        // Asynchronous reset in the middle of RUN
        @(negedge clk);
        a = 8'h5A; b = 8'h3C; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("rstmid_accept", 32'(busy), 32'd1);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_done", 32'(done), 32'd0);
        check("rstmid_sum", 32'(sum), 32'd0);
        check("rstmid_cout", 32'(cout), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        k = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) k++;
        end
        check("rstmid_no_activity", 32'(k), 32'd0);
        run_op(mk(8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0), "post_rst");

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
